goertzel_scan_ctrl: RTL and testbench
=====================================

Name: goertzel_scan_ctrl

Overview:
- Time-shares one Goertzel power engine (16-bit sample in, 32-bit power out, start/done handshake) across NUM_CH antenna channels.
- Sequences channels round-robin: selects the input mux, lets the mux settle, starts the engine, collects the power, and tracks the peak.
- At the end of each sweep it publishes a frame of all powers plus the peak channel.
- Sits between the per-channel sample decimators and the direction-finding/display logic.

Parameters:
- NUM_CH, 3, number of channels swept per frame (2..8).
- SETTLE_CYCLES, 4, idle cycles after a mux change before start (minimum 1).
- TIMEOUT_CYCLES, 1048576, max cycles waited for engine done per channel.
- POWER_W, 32, engine power width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- enable_i  in  1  level; 1 = sweep continuously.
- ch_sel_o  out  $clog2(NUM_CH)  sample-mux select for the engine input.
- eng_start_o  out  1  one-cycle start pulse to the engine.
- eng_clr_o  out  1  one-cycle synchronous clear to the engine, issued on timeout.
- eng_done_i  in  1  engine done (one-cycle pulse).
- eng_power_i  in  POWER_W  engine result, valid when eng_done_i=1.
- powers_o  out  NUM_CH*POWER_W  per-channel powers of the last frame; ch0 in the LSBs.
- peak_ch_o  out  $clog2(NUM_CH)  index of max power, last frame.
- peak_power_o  out  POWER_W  max power, last frame.
- timeout_o  out  NUM_CH  per-channel timeout flags, last frame.
- frame_valid_o  out  1  one-cycle pulse; all frame outputs update on the same edge.
- busy_o  out  1  1 in any state except IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; channel counter 0; internal accumulators cleared.
- States: IDLE, SETTLE, START, WAIT, STORE, PUBLISH.
- IDLE: when enable_i=1, load ch=0, load settle counter with SETTLE_CYCLES, clear the frame peak and timeout scratch, then go to SETTLE.
- SETTLE: ch_sel_o=ch. Decrement the counter each cycle; when it reaches 0, go to START. Dwell is exactly SETTLE_CYCLES cycles.
- START: eng_start_o=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - eng_done_i=1: capture eng_power_i into scratch[ch], go to STORE.
  - Otherwise increment the timeout counter. At TIMEOUT_CYCLES-1: scratch[ch]=0, tmo[ch]=1, eng_clr_o=1 for one cycle, go to STORE.
  - If done and the timeout terminal count occur in the same cycle, done wins and no timeout is flagged.
- STORE:
  - If scratch[ch] > running peak (unsigned, strict), update peak and peak index. Ties therefore keep the lowest index.
  - The first channel always seeds the peak.
  - If ch==NUM_CH-1, go to PUBLISH. Otherwise increment ch, reload the settle counter, and go to SETTLE.
- PUBLISH:
  - Copy scratch to powers_o, tmo to timeout_o, and the peak to peak_ch_o/peak_power_o; pulse frame_valid_o.
  - If enable_i=1, restart the sweep at ch=0 via SETTLE (same clears as IDLE). Otherwise go to IDLE.
- enable_i deassert mid-frame: the current frame completes and publishes, then IDLE. No abort.
- eng_done_i outside WAIT is ignored.
- Latency per channel (no timeout): SETTLE_CYCLES + 1 + engine latency + 1 cycles. PUBLISH adds 1 cycle per frame.
- Frame outputs hold between frame_valid_o pulses.
- ch_sel_o holds its value through START/WAIT/STORE.
- Reset mid-operation: immediate return to reset values. No partial frame is published.

Decomposition:
- Package goertzel_ctrl_pkg: scan_state_t enum (6 states), POWER_W default, and function ch_w(n) returning $clog2(n).
- One natural sub-module, scan_peak_tracker: clear/load/compare register holding peak value and index, with strict-greater rule.
- Timers stay inline in the controller.

Test Plan:
- NUM_CH=3, SETTLE=4, engine model answers 10 cycles after start with powers {100, 300, 200} → one frame_valid_o; powers_o={200,300,100} (ch2..ch0); peak_ch_o=1; peak_power_o=300; timeout_o=0. Measure start-to-start spacing per channel = 4+1+10+1.
- Ties {500, 500, 20} → peak_ch_o=0, peak_power_o=500.
- Engine never answers on ch1, TIMEOUT_CYCLES=64 → eng_clr_o pulses once, 64 cycles after start; powers_o ch1=0; timeout_o=3'b010; frame still publishes.
- eng_done_i in the same cycle as timeout terminal count → power captured, timeout_o bit stays 0, no eng_clr_o.
- enable_i dropped during ch1 WAIT → frame completes and publishes, then IDLE with busy_o=0 and no further eng_start_o. Held high → back-to-back frames with one PUBLISH cycle between.
- rst asserted in WAIT of ch2 → all outputs 0 asynchronously, no frame_valid_o. After release with enable_i=1, the sweep restarts at ch0.

Source files
------------

// File: rtl/goertzel_ctrl_pkg.sv
// rtl/goertzel_ctrl_pkg.sv - shared types and helpers for the Goertzel channel scan controller
package goertzel_ctrl_pkg;

    localparam int DEF_POWER_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_STORE,
        S_PUBLISH
    } scan_state_t;

    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_peak_tracker.sv
// rtl/scan_peak_tracker.sv - running peak value/index register with strict-greater update
module scan_peak_tracker #(
    parameter int VAL_W = 32,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             first_i,
    input  logic [VAL_W-1:0] val_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [VAL_W-1:0] peak_o,
    output logic [IDX_W-1:0] peak_idx_o
);

    logic [VAL_W-1:0] peak_q, peak_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Strict compare keeps the lowest index on ties; first_i seeds unconditionally.
    always_comb begin
        peak_d = peak_q;
        idx_d  = idx_q;
        if (clr_i) begin
            peak_d = '0;
            idx_d  = '0;
        end else if (en_i && (first_i || (val_i > peak_q))) begin
            peak_d = val_i;
            idx_d  = idx_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
            idx_q  <= '0;
        end else begin
            peak_q <= peak_d;
            idx_q  <= idx_d;
        end
    end

    assign peak_o     = peak_q;
    assign peak_idx_o = idx_q;

endmodule

// File: rtl/goertzel_scan_ctrl.sv
// rtl/goertzel_scan_ctrl.sv - round-robin sequencer sharing one Goertzel engine across channels
module goertzel_scan_ctrl
    import goertzel_ctrl_pkg::*;
#(
    parameter int NUM_CH         = 3,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int POWER_W        = DEF_POWER_W,
    localparam int CH_W          = ch_w(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_i,
    output logic [CH_W-1:0]           ch_sel_o,
    output logic                      eng_start_o,
    output logic                      eng_clr_o,
    input  logic                      eng_done_i,
    input  logic [POWER_W-1:0]        eng_power_i,
    output logic [NUM_CH*POWER_W-1:0] powers_o,
    output logic [CH_W-1:0]           peak_ch_o,
    output logic [POWER_W-1:0]        peak_power_o,
    output logic [NUM_CH-1:0]         timeout_o,
    output logic                      frame_valid_o,
    output logic                      busy_o
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    scan_state_t state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [NUM_CH-1:0]  tmo_q, tmo_d;
    logic [POWER_W-1:0] scratch_q [NUM_CH];

    logic               cap_en;
    logic [POWER_W-1:0] cap_val;
    logic               pk_clr, pk_en, publish;
    logic [POWER_W-1:0] pk_val;
    logic [CH_W-1:0]    pk_idx;

    logic [NUM_CH*POWER_W-1:0] powers_q;
    logic [CH_W-1:0]           peak_ch_q;
    logic [POWER_W-1:0]        peak_power_q;
    logic [NUM_CH-1:0]         timeout_q;
    logic                      frame_valid_q;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        settle_d    = settle_q;
        tmo_cnt_d   = tmo_cnt_q;
        tmo_d       = tmo_q;
        cap_en      = 1'b0;
        cap_val     = eng_power_i;
        eng_start_o = 1'b0;
        eng_clr_o   = 1'b0;
        pk_clr      = 1'b0;
        pk_en       = 1'b0;
        publish     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    ch_d     = '0;
                    settle_d = SET_W'(SETTLE_CYCLES);
                    tmo_d    = '0;
                    pk_clr   = 1'b1;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q - SET_W'(1);
                if (settle_q == SET_W'(1)) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                eng_start_o = 1'b1;
                tmo_cnt_d   = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // A done landing on the terminal count is still a valid answer.
                if (eng_done_i) begin
                    cap_en  = 1'b1;
                    state_d = S_STORE;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    cap_en      = 1'b1;
                    cap_val     = '0;
                    tmo_d[ch_q] = 1'b1;
                    eng_clr_o   = 1'b1;
                    state_d     = S_STORE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_STORE: begin
                pk_en = 1'b1;
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d = S_PUBLISH;
                end else begin
                    ch_d     = ch_q + CH_W'(1);
                    settle_d = SET_W'(SETTLE_CYCLES);
                    state_d  = S_SETTLE;
                end
            end
            S_PUBLISH: begin
                publish = 1'b1;
                ch_d    = '0;
                if (enable_i) begin
                    settle_d = SET_W'(SETTLE_CYCLES);
                    tmo_d    = '0;
                    pk_clr   = 1'b1;
                    state_d  = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ch_q          <= '0;
            settle_q      <= '0;
            tmo_cnt_q     <= '0;
            tmo_q         <= '0;
            powers_q      <= '0;
            peak_ch_q     <= '0;
            peak_power_q  <= '0;
            timeout_q     <= '0;
            frame_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            settle_q      <= settle_d;
            tmo_cnt_q     <= tmo_cnt_d;
            tmo_q         <= tmo_d;
            frame_valid_q <= publish;
            if (cap_en) begin
                scratch_q[ch_q] <= cap_val;
            end
            // Frame outputs and the valid pulse change together on the PUBLISH exit edge.
            if (publish) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    powers_q[i*POWER_W +: POWER_W] <= scratch_q[i];
                end
                timeout_q    <= tmo_q;
                peak_ch_q    <= pk_idx;
                peak_power_q <= pk_val;
            end
        end
    end

    scan_peak_tracker #(
        .VAL_W (POWER_W),
        .IDX_W (CH_W)
    ) u_peak (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (pk_clr),
        .en_i       (pk_en),
        .first_i    (ch_q == '0),
        .val_i      (scratch_q[ch_q]),
        .idx_i      (ch_q),
        .peak_o     (pk_val),
        .peak_idx_o (pk_idx)
    );

    assign ch_sel_o      = ch_q;
    assign powers_o      = powers_q;
    assign peak_ch_o     = peak_ch_q;
    assign peak_power_o  = peak_power_q;
    assign timeout_o     = timeout_q;
    assign frame_valid_o = frame_valid_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_goertzel_scan_ctrl.sv
// tb/tb_goertzel_scan_ctrl.sv - directed table-driven bench for goertzel_scan_ctrl
module tb_goertzel_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic [1:0]  ch_sel_o;
    logic        eng_start_o;
    logic        eng_clr_o;
    logic        eng_done_i;
    logic [31:0] eng_power_i;
    logic [95:0] powers_o;
    logic [1:0]  peak_ch_o;
    logic [31:0] peak_power_o;
    logic [2:0]  timeout_o;
    logic        frame_valid_o;
    logic        busy_o;

    goertzel_scan_ctrl #(
        .NUM_CH         (3),
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (64),
        .POWER_W        (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .ch_sel_o      (ch_sel_o),
        .eng_start_o   (eng_start_o),
        .eng_clr_o     (eng_clr_o),
        .eng_done_i    (eng_done_i),
        .eng_power_i   (eng_power_i),
        .powers_o      (powers_o),
        .peak_ch_o     (peak_ch_o),
        .peak_power_o  (peak_power_o),
        .timeout_o     (timeout_o),
        .frame_valid_o (frame_valid_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          passed = 0;
    int          cyc = 0;
    int          clr_cnt = 0;
    int          start_cnt = 0;
    int          fv_cnt = 0;
    int          clr_cyc = 0;
    int          st_cyc [3];
    int          lat_tab [3];
    logic [31:0] pwr_tab [3];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (eng_start_o) begin
            start_cnt          <= start_cnt + 1;
            st_cyc[ch_sel_o]   <= cyc;
        end
        if (eng_clr_o) begin
            clr_cnt <= clr_cnt + 1;
            clr_cyc <= cyc;
        end
        if (frame_valid_o) fv_cnt <= fv_cnt + 1;
    end

    // Engine model: answers lat_tab[ch] cycles after the start cycle; 0 = never answers.
    initial begin
        int c;
        eng_done_i  = 1'b0;
        eng_power_i = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (eng_start_o && !rst) begin
                c = int'(ch_sel_o);
                if (lat_tab[c] != 0) begin
                    repeat (lat_tab[c]) @(negedge clk);
                    eng_done_i  = 1'b1;
                    eng_power_i = pwr_tab[c];
                    @(negedge clk);
                    eng_done_i  = 1'b0;
                    eng_power_i = 32'hDEAD_BEEF;
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_frame(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_valid_o) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_start(input int budget, input logic [1:0] ch, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (eng_start_o && ch_sel_o == ch) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int          l0, l1, l2;
        logic [31:0] p0, p1, p2;
        logic [95:0] exp_powers;
        logic [1:0]  exp_pk_ch;
        logic [31:0] exp_pk;
        logic [2:0]  exp_tmo;
        int          exp_clr;
    } vec_t;

    vec_t vec [8];

    initial begin
        bit got;
        int c0, s0, f0, f1, f2;

        vec[0] = '{10, 10, 10, 32'd100, 32'd300, 32'd200, {32'd200, 32'd300, 32'd100}, 2'd1, 32'd300, 3'b000, 0};
        vec[1] = '{10, 10, 10, 32'd500, 32'd500, 32'd20,  {32'd20,  32'd500, 32'd500}, 2'd0, 32'd500, 3'b000, 0};
        vec[2] = '{10, 0,  10, 32'd100, 32'd999, 32'd200, {32'd200, 32'd0,   32'd100}, 2'd2, 32'd200, 3'b010, 1};
        vec[3] = '{10, 64, 10, 32'd100, 32'd700, 32'd200, {32'd200, 32'd700, 32'd100}, 2'd1, 32'd700, 3'b000, 0};
        vec[4] = '{10, 10, 10, 32'd0,   32'd0,   32'd0,   96'd0,                       2'd0, 32'd0,   3'b000, 0};
        vec[5] = '{10, 10, 10, 32'd900, 32'd5,   32'd7,   {32'd7,   32'd5,   32'd900}, 2'd0, 32'd900, 3'b000, 0};
        vec[6] = '{1,  3,  63, 32'd1,   32'd2,   32'hFFFF_FFFF, {32'hFFFF_FFFF, 32'd2, 32'd1}, 2'd2, 32'hFFFF_FFFF, 3'b000, 0};
        vec[7] = '{0,  10, 0,  32'd55,  32'd40,  32'd66,  {32'd0,   32'd40,  32'd0},   2'd1, 32'd40,  3'b101, 2};

        lat_tab[0] = 10; lat_tab[1] = 10; lat_tab[2] = 10;
        pwr_tab[0] = 0;  pwr_tab[1] = 0;  pwr_tab[2] = 0;
        rst = 1'b1;
        enable_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 1'b0);
        check("rst_frame_valid", frame_valid_o, 1'b0);
        check("rst_powers", powers_o, 96'd0);
        check("rst_ch_sel", ch_sel_o, 2'd0);
        check("rst_start", eng_start_o, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy_o, 1'b0);

        for (int v = 0; v < 8; v++) begin
            lat_tab[0] = vec[v].l0; lat_tab[1] = vec[v].l1; lat_tab[2] = vec[v].l2;
            pwr_tab[0] = vec[v].p0; pwr_tab[1] = vec[v].p1; pwr_tab[2] = vec[v].p2;
            c0 = clr_cnt;
            enable_i = 1'b1;
            @(negedge clk);
            enable_i = 1'b0;
            wait_frame(400, got);
            check($sformatf("v%0d_frame_seen", v), got, 1'b1);
            check($sformatf("v%0d_powers", v), powers_o, vec[v].exp_powers);
            check($sformatf("v%0d_peak_ch", v), peak_ch_o, vec[v].exp_pk_ch);
            check($sformatf("v%0d_peak_power", v), peak_power_o, vec[v].exp_pk);
            check($sformatf("v%0d_timeout", v), timeout_o, vec[v].exp_tmo);
            check($sformatf("v%0d_clr_count", v), clr_cnt - c0, vec[v].exp_clr);
            check($sformatf("v%0d_idle_after", v), busy_o, 1'b0);
            if (v == 0) begin
                check("spacing_ch0_ch1", st_cyc[1] - st_cyc[0], 16);
                check("spacing_ch1_ch2", st_cyc[2] - st_cyc[1], 16);
            end
            if (v == 2) check("clr_after_start", clr_cyc - st_cyc[1], 64);
            @(negedge clk);
        end

        // Frame outputs hold between pulses.
        repeat (20) @(negedge clk);
        check("hold_peak_power", peak_power_o, 32'd40);

        // enable dropped during ch1 WAIT.
        lat_tab[0] = 10; lat_tab[1] = 10; lat_tab[2] = 10;
        pwr_tab[0] = 32'd100; pwr_tab[1] = 32'd300; pwr_tab[2] = 32'd200;
        enable_i = 1'b1;
        wait_start(200, 2'd1, got);
        check("drop_ch1_start_seen", got, 1'b1);
        repeat (2) @(negedge clk);
        enable_i = 1'b0;
        wait_frame(200, got);
        check("drop_frame_seen", got, 1'b1);
        check("drop_peak_power", peak_power_o, 32'd300);
        check("drop_busy", busy_o, 1'b0);
        s0 = start_cnt;
        repeat (60) @(negedge clk);
        check("drop_no_more_starts", start_cnt - s0, 0);
        check("drop_still_idle", busy_o, 1'b0);

        // enable held high: frames back to back with a single PUBLISH cycle between.
        enable_i = 1'b1;
        wait_frame(200, got);
        f1 = cyc;
        wait_frame(200, got);
        f2 = cyc;
        check("b2b_frame_seen", got, 1'b1);
        check("b2b_period", f2 - f1, 49);
        check("b2b_busy", busy_o, 1'b1);
        enable_i = 1'b0;
        wait_frame(200, got);
        check("b2b_last_frame", got, 1'b1);

        // Reset in ch2 WAIT.
        repeat (3) @(negedge clk);
        enable_i = 1'b1;
        wait_start(200, 2'd2, got);
        check("rst_ch2_start_seen", got, 1'b1);
        repeat (3) @(negedge clk);
        f0 = fv_cnt;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_ch_sel", ch_sel_o, 2'd0);
        check("mid_rst_powers", powers_o, 96'd0);
        check("mid_rst_peak_ch", peak_ch_o, 2'd0);
        check("mid_rst_peak_power", peak_power_o, 32'd0);
        check("mid_rst_timeout", timeout_o, 3'd0);
        check("mid_rst_frame_valid", frame_valid_o, 1'b0);
        repeat (20) @(negedge clk);
        check("mid_rst_no_frame", fv_cnt - f0, 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            if (eng_start_o) break;
            @(negedge clk);
        end
        check("restart_start_seen", eng_start_o, 1'b1);
        check("restart_ch0", ch_sel_o, 2'd0);
        enable_i = 1'b0;
        wait_frame(200, got);
        check("restart_frame_seen", got, 1'b1);
        check("restart_powers", powers_o, {32'd200, 32'd300, 32'd100});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
